background_tile_renderer: RTL and testbench
===========================================

# background_tile_renderer

Consumer end of the screen-drawer interface. Every screen drawer publishes a 12×17 `background` tile map and sprite coordinates. This block scans the 640×480 VGA raster, looks up the tile under each pixel, overlays the Mario and two Goomba boxes, and drives registered RGB and sync to the DAC. It sits between the active screen drawer's outputs and the VGA pins.

## Interface
- `BDR`, `SKY`, `BLK`, `GND`, `TKN`, `CK1`, `CK2`: defaults 0–6; tile codes, identical to the drawers.
- `BLOCK_WIDTH`: default 40; tile edge, in pixels.
- `CHARACTER_WIDTH`: default 42; sprite box edge, in pixels.
- `H_VISIBLE`, `H_FRONT`, `H_SYNC`, `H_BACK`: defaults 640, 16, 96, 48. H_TOTAL = 800.
- `V_VISIBLE`, `V_FRONT`, `V_SYNC`, `V_BACK`: defaults 480, 10, 2, 33. V_TOTAL = 525.
- `vga_clock`: input, 1 bit; 25 MHz pixel clock, the only clock.
- `reset`: input, 1 bit; asynchronous, active-low.
- `background`: input, byte [11:0][16:0]; tile map.
- `mario_x`, `mario_y`, `goomba_x`, `goomba_y`, `goomba_2x`, `goomba_2y`: input, int each; sprite top-left corners in screen pixels, signed.
- `vga_hs`, `vga_vs`: output, 1 bit each; syncs, active-low.
- `vga_blank_n`: output, 1 bit; high during the visible region.
- `vga_r`, `vga_g`, `vga_b`: output, 8 bits each; pixel colour.
- `frame_start`: output, 1 bit; one-cycle pulse at the start of vertical blank.

## Operation
- Raster counters:
  - `hcount` runs 0..799 and `vcount` runs 0..524.
  - `vcount` increments when `hcount` wraps 799→0.
  - Both wrap at their totals.
- Tile counters run alongside, with no divider:
  - `tx_sub` counts 0..39 and `tile_col` counts 0..15; `ty_sub` and `tile_row` behave the same for rows.
  - `tx_sub` wraps at 39 and increments `tile_col`.
  - All tile counters clear when `hcount`/`vcount` leave the visible region.
- Map indexing:
  - Screen tile (col c, row r), top-left origin, reads `background[11-r][16-c]`.
  - Index column 0 is never displayed.
- Sprite hit for a sprite at (sx, sy): `sx <= px < sx+CHARACTER_WIDTH` and `sy <= py < sy+CHARACTER_WIDTH`.
  - Comparison is 32-bit signed, so negative or ≥640 positions render partially or not at all.
  - Position 1000 is invisible.
- Colour priority: Mario, then Goomba 1, then Goomba 2, then tile.
- Palette:
  - BDR: 000000
  - SKY: 5C94FC
  - BLK: C84C0C
  - GND: 8B4513
  - TKN: FFD700
  - CK1: FFFFFF
  - CK2: 202020
  - Any other code: FF00FF (debug magenta)
  - Mario: E52521
  - Goomba: 8B5A2B
- Outside the visible region, RGB is forced to 0 and `vga_blank_n` is 0.
- Sprite coordinates are latched into shadow registers on the cycle `hcount`=0, `vcount`=480, the same cycle that asserts `frame_start`. This guarantees no mid-frame tearing.
- `background` is sampled live; drawers hold it static.

## Timing
- Pipeline stages:
  - Stage 0: counters.
  - Stage 1: map read and the three hit compares, registered.
  - Stage 2: priority mux and palette into the output registers.
- Output latency is 2 cycles. `vga_hs`, `vga_vs` and `vga_blank_n` pass through a matching 2-stage delay, so pixel (0,0) appears on RGB two cycles after `hcount`=`vcount`=0.
- Sync windows, both active-low:
  - `vga_hs` is low for `hcount` 656..751.
  - `vga_vs` is low for `vcount` 490..491.
- Reset asserted, at any time and including mid-frame:
  - All counters go to 0.
  - RGB = 0, `vga_hs` = `vga_vs` = 1, `vga_blank_n` = 0, `frame_start` = 0.
  - Shadow sprite registers hold 1000, i.e. off-screen.
- Scan resumes from (0,0) on the first `vga_clock` edge after release. The first `frame_start` occurs 480×800 cycles later.

## Structure
- Shared package `vga_pkg` holds:
  - the tile-code localparams;
  - the timing constants;
  - the `rgb_t` typedef (8/8/8 struct);
  - the palette function `tile_to_rgb(byte) -> rgb_t`.
- Sub-module `vga_timing`, instantiated once, owns `hcount`/`vcount`, the tile sub-counters, the visible flag, `frame_start` and the raw syncs.
- This block owns the latch, the compares, the mux and the delay line.

## Test plan
- Reset release with an all-SKY map and all sprites at 1000 → first visible pixel is RGB 5C94FC at cycle 2; `vga_hs` first falls at cycle 656+2.
- Map with only `background[11][16]` = GND → pixels (0..39, 0..39) are 8B4513 and pixel (40,0) is not; checks the index reversal.
- `mario_x`=100, `mario_y`=200 → (100,200) and (141,241) are E52521; (142,200) and (99,200) are background.
- Mario and Goomba 1 both at (300,300) → E52521 wins. Goomba 2 at (-20,0) → columns 0..21 of rows 0..41 are 8B5A2B.
- Change `mario_x` mid-frame at `vcount`=100 → the current frame is unchanged; the new position appears after `frame_start`. Also: `background` code 9 → FF00FF.
- Assert reset at `vcount`=250 → outputs take reset values within the same cycle, asynchronously; after release, `vcount` restarts at 0 and two full frames keep exact 800×525 periodicity.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: tile codes, 640x480@60 VGA timing, the 8/8/8 colour type and the
// tile palette, shared by the screen drawers and the background renderer.
package vga_pkg;

    localparam logic [7:0] TILE_BDR = 8'd0;
    localparam logic [7:0] TILE_SKY = 8'd1;
    localparam logic [7:0] TILE_BLK = 8'd2;
    localparam logic [7:0] TILE_GND = 8'd3;
    localparam logic [7:0] TILE_TKN = 8'd4;
    localparam logic [7:0] TILE_CK1 = 8'd5;
    localparam logic [7:0] TILE_CK2 = 8'd6;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SW    = 96;
    localparam int H_BP    = 48;
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SW    = 2;
    localparam int V_BP    = 33;
    localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;

    localparam int TILE_PX   = 40;
    localparam int SPRITE_PX = 42;
    localparam int OFFSCREEN = 1000;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t MARIO_RGB  = 24'hE52521;
    localparam rgb_t GOOMBA_RGB = 24'h8B5A2B;

    // Unknown codes show up magenta so a drawer bug is obvious on screen.
    function automatic rgb_t tile_to_rgb(input logic [7:0] code);
        return code == TILE_BDR ? 24'h000000 :
               code == TILE_SKY ? 24'h5C94FC :
               code == TILE_BLK ? 24'hC84C0C :
               code == TILE_GND ? 24'h8B4513 :
               code == TILE_TKN ? 24'hFFD700 :
               code == TILE_CK1 ? 24'hFFFFFF :
               code == TILE_CK2 ? 24'h202020 : 24'hFF00FF;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster and tile counters for the VGA scan, plus the visible
// flag, raw active-low syncs and the start-of-vertical-blank pulse.
module vga_timing
    import vga_pkg::*;
#(
    parameter int BLOCK_WIDTH = TILE_PX,
    parameter int H_VISIBLE   = H_VIS,
    parameter int H_FRONT     = H_FP,
    parameter int H_SYNC      = H_SW,
    parameter int H_BACK      = H_BP,
    parameter int V_VISIBLE   = V_VIS,
    parameter int V_FRONT     = V_FP,
    parameter int V_SYNC      = V_SW,
    parameter int V_BACK      = V_BP
) (
    input  logic       vga_clock,
    input  logic       reset,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic [3:0] tile_col,
    output logic [3:0] tile_row,
    output logic       visible,
    output logic       frame_start,
    output logic       hs_raw,
    output logic       vs_raw
);

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS_L  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_L  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [5:0] SUB_LAST = 6'(BLOCK_WIDTH - 1);

    logic [9:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic [5:0] tx_sub_q, tx_sub_d, ty_sub_q, ty_sub_d;
    logic [3:0] tile_col_q, tile_col_d, tile_row_q, tile_row_d;
    logic       h_wrap, h_run, v_run;

    // Tile counters advance only while the next position stays inside the
    // visible area; a restart at 0 or a step into blanking clears them.
    always_comb begin
        h_wrap     = hcount_q == H_LAST;
        hcount_d   = h_wrap ? '0 : hcount_q + 10'd1;
        vcount_d   = !h_wrap ? vcount_q : vcount_q == V_LAST ? '0 : vcount_q + 10'd1;
        h_run      = hcount_d != '0 && hcount_d < H_VIS_L;
        v_run      = vcount_d != '0 && vcount_d < V_VIS_L;
        tx_sub_d   = h_run && tx_sub_q != SUB_LAST ? tx_sub_q + 6'd1 : '0;
        tile_col_d = !h_run ? '0 : tx_sub_q == SUB_LAST ? tile_col_q + 4'd1 : tile_col_q;
        ty_sub_d   = !h_wrap ? ty_sub_q : v_run && ty_sub_q != SUB_LAST ? ty_sub_q + 6'd1 : '0;
        tile_row_d = !h_wrap ? tile_row_q : !v_run ? '0 :
                     ty_sub_q == SUB_LAST ? tile_row_q + 4'd1 : tile_row_q;
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            hcount_q   <= '0;
            vcount_q   <= '0;
            tx_sub_q   <= '0;
            ty_sub_q   <= '0;
            tile_col_q <= '0;
            tile_row_q <= '0;
        end else begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            tx_sub_q   <= tx_sub_d;
            ty_sub_q   <= ty_sub_d;
            tile_col_q <= tile_col_d;
            tile_row_q <= tile_row_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign tile_col    = tile_col_q;
    assign tile_row    = tile_row_q;
    assign visible     = hcount_q < H_VIS_L && vcount_q < V_VIS_L;
    assign frame_start = hcount_q == '0 && vcount_q == V_VIS_L;
    assign hs_raw      = !(hcount_q >= HS_BEG && hcount_q < HS_END);
    assign vs_raw      = !(vcount_q >= VS_BEG && vcount_q < VS_END);

endmodule

// File: rtl/background_tile_renderer.sv
// background_tile_renderer: scans the VGA raster, draws the drawer's tile map
// with Mario and two Goomba boxes on top, and drives registered RGB and syncs.
module background_tile_renderer
    import vga_pkg::*;
#(
    parameter logic [7:0] BDR = TILE_BDR,
    parameter logic [7:0] SKY = TILE_SKY,
    parameter logic [7:0] BLK = TILE_BLK,
    parameter logic [7:0] GND = TILE_GND,
    parameter logic [7:0] TKN = TILE_TKN,
    parameter logic [7:0] CK1 = TILE_CK1,
    parameter logic [7:0] CK2 = TILE_CK2,
    parameter int BLOCK_WIDTH     = TILE_PX,
    parameter int CHARACTER_WIDTH = SPRITE_PX,
    parameter int H_VISIBLE       = H_VIS,
    parameter int H_FRONT         = H_FP,
    parameter int H_SYNC          = H_SW,
    parameter int H_BACK          = H_BP,
    parameter int V_VISIBLE       = V_VIS,
    parameter int V_FRONT         = V_FP,
    parameter int V_SYNC          = V_SW,
    parameter int V_BACK          = V_BP
) (
    input  logic                     vga_clock,
    input  logic                     reset,
    input  logic [11:0][16:0][7:0]   background,
    input  logic signed [31:0]       mario_x,
    input  logic signed [31:0]       mario_y,
    input  logic signed [31:0]       goomba_x,
    input  logic signed [31:0]       goomba_y,
    input  logic signed [31:0]       goomba_2x,
    input  logic signed [31:0]       goomba_2y,
    output logic                     vga_hs,
    output logic                     vga_vs,
    output logic                     vga_blank_n,
    output logic [7:0]               vga_r,
    output logic [7:0]               vga_g,
    output logic [7:0]               vga_b,
    output logic                     frame_start
);

    logic [9:0]         hcount, vcount;
    logic [3:0]         tile_col, tile_row;
    logic               visible, hs_raw, vs_raw;
    logic signed [31:0] px, py;
    logic [7:0]         code_raw;
    logic [5:0][31:0]   spr_q, spr_d;
    logic [7:0]         code_q, code_d;
    logic [2:0]         hit_q, hit_d;
    logic               vis1_q, vis1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    rgb_t               rgb_q, rgb_d;
    logic               hs2_q, hs2_d, vs2_q, vs2_d, blank_q, blank_d;

    vga_timing #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .H_VISIBLE   (H_VISIBLE),
        .H_FRONT     (H_FRONT),
        .H_SYNC      (H_SYNC),
        .H_BACK      (H_BACK),
        .V_VISIBLE   (V_VISIBLE),
        .V_FRONT     (V_FRONT),
        .V_SYNC      (V_SYNC),
        .V_BACK      (V_BACK)
    ) u_timing (
        .vga_clock   (vga_clock),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .tile_col    (tile_col),
        .tile_row    (tile_row),
        .visible     (visible),
        .frame_start (frame_start),
        .hs_raw      (hs_raw),
        .vs_raw      (vs_raw)
    );

    function automatic logic hit(input logic signed [31:0] x, y, sx, sy);
        return x >= sx && x < sx + CHARACTER_WIDTH && y >= sy && y < sy + CHARACTER_WIDTH;
    endfunction

    // The map is stored bottom-right first, hence the reversed indices; codes
    // are translated to the package encoding so the palette stays shared.
    always_comb begin
        px       = $signed({22'd0, hcount});
        py       = $signed({22'd0, vcount});
        spr_d    = frame_start ? {goomba_2y, goomba_2x, goomba_y, goomba_x, mario_y, mario_x} : spr_q;
        code_raw = background[4'd11 - tile_row][5'd16 - {1'b0, tile_col}];
        code_d   = code_raw == BDR ? TILE_BDR : code_raw == SKY ? TILE_SKY :
                   code_raw == BLK ? TILE_BLK : code_raw == GND ? TILE_GND :
                   code_raw == TKN ? TILE_TKN : code_raw == CK1 ? TILE_CK1 :
                   code_raw == CK2 ? TILE_CK2 : 8'hFF;
        hit_d    = {hit(px, py, spr_q[4], spr_q[5]),
                    hit(px, py, spr_q[2], spr_q[3]),
                    hit(px, py, spr_q[0], spr_q[1])};
        vis1_d   = visible;
        hs1_d    = hs_raw;
        vs1_d    = vs_raw;
        rgb_d    = !vis1_q ? '0 : hit_q[0] ? MARIO_RGB : |hit_q[2:1] ? GOOMBA_RGB : tile_to_rgb(code_q);
        hs2_d    = hs1_q;
        vs2_d    = vs1_q;
        blank_d  = vis1_q;
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            spr_q   <= {6{32'(OFFSCREEN)}};
            code_q  <= '0;
            hit_q   <= '0;
            vis1_q  <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            rgb_q   <= '0;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
            blank_q <= 1'b0;
        end else begin
            spr_q   <= spr_d;
            code_q  <= code_d;
            hit_q   <= hit_d;
            vis1_q  <= vis1_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            rgb_q   <= rgb_d;
            hs2_q   <= hs2_d;
            vs2_q   <= vs2_d;
            blank_q <= blank_d;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb_q;
    assign vga_hs      = hs2_q;
    assign vga_vs      = vs2_q;
    assign vga_blank_n = blank_q;

endmodule

// File: tb/tb_background_tile_renderer.sv
// tb_background_tile_renderer: scaled-down raster (80x55, 4-pixel tiles, 5-pixel
// sprites) checked every cycle against a pixel-level model of the display rules.
module tb_background_tile_renderer;

    localparam int BW  = 4;
    localparam int CW  = 5;
    localparam int HV  = 64, HF = 4, HSW = 8, HB = 4;
    localparam int VV  = 48, VF = 2, VSW = 2, VB = 3;
    localparam int HT  = HV + HF + HSW + HB;
    localparam int VT  = VV + VF + VSW + VB;
    localparam int FR  = HT * VT;
    localparam int FSQ = VV * HT;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [11:0][16:0][7:0] bg;
    int                     mx, my, g1x, g1y, g2x, g2y;
    logic                   hs, vs, blank_n, fs;
    logic [7:0]             r, g, b;

    int          n_tests = 0;
    int          n_fail = 0;
    int          n = 0;
    int          sh [6];
    logic [23:0] cap [HV][VV];
    int          first_vis = -1;
    int          first_hsl = -1;
    logic [23:0] e_rgb;
    logic        e_hs, e_vs, e_bl;
    int          p, ph, pv;

    background_tile_renderer #(
        .BLOCK_WIDTH(BW), .CHARACTER_WIDTH(CW),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
    ) dut (
        .vga_clock(clk), .reset(rst_n), .background(bg),
        .mario_x(mx), .mario_y(my), .goomba_x(g1x), .goomba_y(g1y),
        .goomba_2x(g2x), .goomba_2y(g2y),
        .vga_hs(hs), .vga_vs(vs), .vga_blank_n(blank_n),
        .vga_r(r), .vga_g(g), .vga_b(b), .frame_start(fs)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else n <= n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    function automatic logic [23:0] pal(input logic [7:0] c);
        case (c)
            8'd0:    return 24'h000000;
            8'd1:    return 24'h5C94FC;
            8'd2:    return 24'hC84C0C;
            8'd3:    return 24'h8B4513;
            8'd4:    return 24'hFFD700;
            8'd5:    return 24'hFFFFFF;
            8'd6:    return 24'h202020;
            default: return 24'hFF00FF;
        endcase
    endfunction

    function automatic bit inbox(input int h, input int v, input int sx, input int sy);
        return h >= sx && h < sx + CW && v >= sy && v < sy + CW;
    endfunction

    function automatic logic [23:0] model_pix(input int h, input int v);
        if (inbox(h, v, sh[0], sh[1])) return 24'hE52521;
        if (inbox(h, v, sh[2], sh[3]) || inbox(h, v, sh[4], sh[5])) return 24'h8B5A2B;
        return pal(bg[11 - v / BW][16 - h / BW]);
    endfunction

    // Outputs after edge n show raster pixel n-2; the raster counter itself is at n.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) sh[i] = 1000;
            e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0;
        end else begin
            if (n % FR == FSQ) begin
                sh[0] = mx; sh[1] = my; sh[2] = g1x; sh[3] = g1y; sh[4] = g2x; sh[5] = g2y;
            end
            if (n < 2) begin
                e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0;
            end else begin
                p     = n - 2;
                ph    = p % HT;
                pv    = (p / HT) % VT;
                e_bl  = ph < HV && pv < VV;
                e_hs  = !(ph >= HV + HF && ph < HV + HF + HSW);
                e_vs  = !(pv >= VV + VF && pv < VV + VF + VSW);
                e_rgb = e_bl ? model_pix(ph, pv) : 24'h0;
                if (e_bl) cap[ph][pv] = {r, g, b};
            end
        end
        check("rgb", {8'h0, r, g, b}, {8'h0, e_rgb});
        check("hsync", 32'(hs), 32'(e_hs));
        check("vsync", 32'(vs), 32'(e_vs));
        check("blank_n", 32'(blank_n), 32'(e_bl));
        check("frame_start", 32'(fs), 32'(rst_n && n % FR == FSQ));
        if (blank_n && first_vis < 0) first_vis = n;
        if (!hs && first_hsl < 0) first_hsl = n;
    end

    task automatic wait_n(input int t);
        int k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (n % FR != t && k < FR + 5);
        if (n % FR != t) begin
            n_tests++; n_fail++;
            $display("FAIL wait_timeout: frame offset %0d never reached %0d", n % FR, t);
        end
    endtask

    task automatic fill_bg(input logic [7:0] c);
        for (int i = 0; i < 12; i++)
            for (int j = 0; j < 17; j++) bg[i][j] = c;
    endtask

    task automatic rand_bg();
        for (int i = 0; i < 12; i++)
            for (int j = 0; j < 17; j++) bg[i][j] = 8'($urandom_range(0, 9));
    endtask

    function automatic int rpos();
        return ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 80)) - 10;
    endfunction

    task automatic rand_sprites();
        mx = rpos(); my = rpos(); g1x = rpos(); g1y = rpos(); g2x = rpos(); g2y = rpos();
    endtask

    initial begin
        int fs_n [2];
        int k;
        fill_bg(8'd1);
        mx = 1000; my = 1000; g1x = 1000; g1y = 1000; g2x = 1000; g2y = 1000;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        // Frame 0: sprites all off; a mid-frame move must wait for the next frame.
        wait_n(10 * HT);
        mx = 10; my = 20;
        wait_n(3900);
        check("first_visible_edge", first_vis, 2);
        check("first_hsync_low_edge", first_hsl, 70);
        check("f0_pixel_0_0", cap[0][0], 24'h5C94FC);
        check("f0_mario_not_yet", cap[10][20], 24'h5C94FC);
        fill_bg(8'd1);
        bg[11][16] = 8'd3;
        // Frame 1: GND only in the top-left tile, Mario at (10,20).
        wait_n(3000);
        mx = 30; my = 30; g1x = 30; g1y = 30; g2x = -2; g2y = 0;
        wait_n(3900);
        check("f1_gnd_0_0", cap[0][0], 24'h8B4513);
        check("f1_gnd_3_3", cap[3][3], 24'h8B4513);
        check("f1_sky_4_0", cap[4][0], 24'h5C94FC);
        check("f1_sky_0_4", cap[0][4], 24'h5C94FC);
        check("f1_mario_tl", cap[10][20], 24'hE52521);
        check("f1_mario_br", cap[14][24], 24'hE52521);
        check("f1_mario_right_edge", cap[15][20], 24'h5C94FC);
        check("f1_mario_left_edge", cap[9][20], 24'h5C94FC);
        fill_bg(8'd1);
        bg[9][13] = 8'd9;
        // Frame 2: Mario over Goomba 1, Goomba 2 clipped at the left edge, bad code.
        wait_n(3000);
        rand_sprites();
        wait_n(3900);
        check("f2_mario_priority", cap[30][30], 24'hE52521);
        check("f2_mario_priority_br", cap[34][34], 24'hE52521);
        check("f2_after_boxes", cap[35][30], 24'h5C94FC);
        check("f2_goomba2_0_0", cap[0][0], 24'h8B5A2B);
        check("f2_goomba2_2_4", cap[2][4], 24'h8B5A2B);
        check("f2_goomba2_col3", cap[3][0], 24'h5C94FC);
        check("f2_goomba2_row5", cap[0][5], 24'h5C94FC);
        check("f2_magenta", cap[12][8], 24'hFF00FF);
        check("f2_magenta_br", cap[15][11], 24'hFF00FF);
        rand_bg();
        repeat (3) begin
            wait_n(3000);
            rand_sprites();
            wait_n(3900);
            rand_bg();
        end
        // Asynchronous reset in the middle of visible line 25.
        wait_n(25 * HT + 10);
        rst_n = 1'b0;
        #1;
        check("async_rst_rgb", {8'h0, r, g, b}, 32'h0);
        check("async_rst_hs", 32'(hs), 32'd1);
        check("async_rst_vs", 32'(vs), 32'd1);
        check("async_rst_blank", 32'(blank_n), 32'd0);
        check("async_rst_fs", 32'(fs), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int j = 0; j < 2; j++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!fs && k < 2 * FR);
            fs_n[j] = n;
            check("frame_start_seen", 32'(fs), 32'd1);
            @(negedge clk);
        end
        check("first_frame_start_edge", fs_n[0], 3840);
        check("frame_period", fs_n[1] - fs_n[0], 4400);
        wait_n(1000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
